// File: rtl/eth_arb_pkg.sv
// Shared types and default constants for the Ethernet TX arbiter.
// Requester indices name the fixed frame sources on the arbiter inputs.
package eth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_MAX_WORDS = 64;

  localparam int REQ_TCP  = 0;
  localparam int REQ_ARP  = 1;
  localparam int REQ_ICMP = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// when searching from ptr+1 upward, wrapping modulo N.
module rr_pick #(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  // Scan from the farthest slot back to the nearest so the nearest request
  // after ptr is the last one written and therefore wins.
  always_comb begin
    // NOTE: every output and temporary gets a default first; a path that
    // leaves one unassigned would infer a latch.
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = N; off >= 1; off--) begin
      cand = W'((int'(ptr) + off) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing one Ethernet TX valid/ready channel between
// frame sources; holds the grant per frame and truncates runaway frames.
module eth_tx_arbiter
  import eth_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            eth_tx_data,
  output logic                         eth_tx_valid,
  output logic                         eth_tx_last,
  input  logic                         eth_tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         overrun_err,
  output logic [15:0]                  frame_count
);

  localparam int          GW       = $clog2(NUM_REQ);
  localparam logic [15:0] LAST_IDX = 16'(MAX_WORDS - 1);

  arb_state_t        state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              overrun_q, overrun_d;

  logic              found;
  logic [GW-1:0]     pick;
  logic              at_max;
  logic              hs;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick)
  );

  assign at_max = (word_cnt_q == LAST_IDX);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    word_cnt_d    = word_cnt_q;
    frame_count_d = frame_count_q;
    overrun_d     = 1'b0;
    hs            = 1'b0;
    req_ready     = '0;
    eth_tx_data   = '0;
    eth_tx_valid  = 1'b0;
    eth_tx_last   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = pick;
          ptr_d      = pick;
          word_cnt_d = '0;
          state_d    = XFER;
        end
      end

      XFER: begin
        eth_tx_data        = data_arr[grant_q];
        eth_tx_valid       = req_valid[grant_q];
        eth_tx_last        = req_last[grant_q] | at_max;
        req_ready[grant_q] = eth_tx_ready;
        hs                 = req_valid[grant_q] & eth_tx_ready;
        if (hs) begin
          if (!at_max) word_cnt_d = word_cnt_q + 16'd1;
          // A genuine last wins over the watchdog even on the limit word.
          if (req_last[grant_q]) begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = IDLE;
          end else if (at_max) begin
            overrun_d = 1'b1;
            state_d   = DRAIN;
          end
        end
      end

      DRAIN: begin
        req_ready[grant_q] = 1'b1;
        if (req_valid[grant_q] && req_last[grant_q]) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= GW'(NUM_REQ - 1);
      grant_q       <= '0;
      word_cnt_q    <= '0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      word_cnt_q    <= word_cnt_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign overrun_err = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter (MAX_WORDS = 4): single frame, contention,
// backpressure, overrun, mid-frame reset and frame counter wrap.
module tb_eth_tx_arbiter;
  import eth_arb_pkg::*;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int MW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [DW-1:0]   eth_tx_data;
  logic            eth_tx_valid, eth_tx_last, eth_tx_ready;
  logic [1:0]      grant_id;
  logic            busy, overrun_err;
  logic [15:0]     frame_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ovr_cnt;

  int frames_left [N];
  int flen        [N];
  int widx        [N];
  int fnum        [N];

  logic [32:0] cap_q   [$];
  int          cap_cyc [$];

  always #5 clk = ~clk;

  eth_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_WORDS(MW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .eth_tx_data  (eth_tx_data),
    .eth_tx_valid (eth_tx_valid),
    .eth_tx_last  (eth_tx_last),
    .eth_tx_ready (eth_tx_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .overrun_err  (overrun_err),
    .frame_count  (frame_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word payload: {requester, frame number, word index}.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = (frames_left[i] > 0);
      req_last[i]             = (frames_left[i] > 0) && (widx[i] == flen[i] - 1);
      req_data[i*DW +: DW]    = {8'(i), 8'(fnum[i]), 16'(widx[i])};
    end
  endtask

  task automatic set_src(input int i, input int nf, input int len);
    frames_left[i] = nf;
    flen[i]        = len;
    widx[i]        = 0;
    fnum[i]        = 0;
  endtask

  task automatic new_test();
    cyc = 0;
    cap_q.delete();
    cap_cyc.delete();
  endtask

  // Sample handshakes, advance one clock, update the sources, settle.
  task automatic step();
    logic [N-1:0] hs;
    logic [N-1:0] lst;
    hs  = req_valid & req_ready;
    lst = req_last;
    if (eth_tx_valid && eth_tx_ready) begin
      cap_q.push_back({eth_tx_last, eth_tx_data});
      cap_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (lst[i]) begin
          frames_left[i]--;
          fnum[i]++;
          widx[i] = 0;
        end else begin
          widx[i]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic check_frame(input string tag, input int base, input int rq,
                             input int fn, input int len);
    logic [32:0] exp;
    logic [32:0] obs;
    for (int k = 0; k < len; k++) begin
      exp = {(k == len - 1), 8'(rq), 8'(fn), 16'(k)};
      obs = 'x;
      if (base + k < cap_q.size()) obs = cap_q[base + k];
      check(tag, 64'(obs), 64'(exp));
    end
  endtask

  task automatic reset_dut();
    for (int i = 0; i < N; i++) set_src(i, 0, 1);
    eth_tx_ready = 1'b1;
    drive();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) set_src(i, 0, 1);
    eth_tx_ready = 1'b1;
    drive();
    #2;
    reset_dut();

    // Reset state.
    check("rst_req_ready", req_ready, 3'b000);
    check("rst_tx_valid", eth_tx_valid, 1'b0);
    check("rst_tx_last", eth_tx_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun_err, 1'b0);
    check("rst_grant", grant_id, 2'd0);
    check("rst_frame_count", frame_count, 16'd0);

    // Single 4-word frame from the ARP requester.
    new_test();
    set_src(REQ_ARP, 1, 4);
    drive();
    #1;
    check("t1_idle_valid", eth_tx_valid, 1'b0);
    step();
    check("t1_first_valid", eth_tx_valid, 1'b1);
    check("t1_first_data", eth_tx_data, 32'h0100_0000);
    check("t1_grant", grant_id, 2'd1);
    repeat (4) step();
    check("t1_count", cap_q.size(), 4);
    check_frame("t1_word", 0, 1, 0, 4);
    check("t1_first_cyc", cap_cyc[0], 1);
    check("t1_frame_count", frame_count, 16'd1);
    check("t1_busy", busy, 1'b0);

    // Contention: all three hold 3-word frames from reset, requester 0 has two.
    reset_dut();
    new_test();
    set_src(REQ_TCP, 2, 3);
    set_src(REQ_ARP, 1, 3);
    set_src(REQ_ICMP, 1, 3);
    drive();
    #1;
    repeat (18) step();
    check("t2_count", cap_q.size(), 12);
    check_frame("t2_f0", 0, 0, 0, 3);
    check_frame("t2_f1", 3, 1, 0, 3);
    check_frame("t2_f2", 6, 2, 0, 3);
    check_frame("t2_f3", 9, 0, 1, 3);
    for (int f = 0; f < 4; f++) begin
      if (3 * f < cap_cyc.size()) check("t2_frame_start", cap_cyc[3*f], 1 + 4 * f);
    end
    check("t2_frame_count", frame_count, 16'd4);

    // Backpressure on a 4-word ICMP frame.
    new_test();
    set_src(REQ_ICMP, 1, 4);
    drive();
    #1;
    check("t3_idle_ready", req_ready, 3'b000);
    for (int k = 1; k <= 8; k++) begin
      step();
      eth_tx_ready = (k % 2 == 1);
      #1;
      check("t3_req_ready", req_ready, (k <= 7) ? {eth_tx_ready, 2'b00} : 3'b000);
    end
    eth_tx_ready = 1'b1;
    check("t3_count", cap_q.size(), 4);
    check_frame("t3_word", 0, 2, 0, 4);
    if (cap_cyc.size() == 4) begin
      check("t3_cyc1", cap_cyc[1], 3);
      check("t3_cyc3", cap_cyc[3], 7);
    end
    check("t3_frame_count", frame_count, 16'd5);

    // Overrun: TCP sends 7 words against a 4-word limit, then ARP is served.
    new_test();
    set_src(REQ_TCP, 1, 7);
    set_src(REQ_ARP, 1, 2);
    drive();
    #1;
    ovr_cnt = int'(overrun_err);
    for (int k = 1; k <= 12; k++) begin
      step();
      ovr_cnt += int'(overrun_err);
      if (k == 5) begin
        check("t4_ovr_pulse", overrun_err, 1'b1);
        check("t4_drain_valid", eth_tx_valid, 1'b0);
        check("t4_drain_ready", req_ready, 3'b001);
        check("t4_drain_busy", busy, 1'b1);
      end
      if (k == 8) check("t4_fc_kept", frame_count, 16'd5);
      if (k == 9) check("t4_next_grant", grant_id, 2'd1);
    end
    check("t4_ovr_once", ovr_cnt, 1);
    check("t4_count", cap_q.size(), 6);
    check_frame("t4_trunc", 0, 0, 0, 4);
    check_frame("t4_arp", 4, 1, 0, 2);
    check("t4_frame_count", frame_count, 16'd6);

    // Reset in the middle of a 5-word TCP frame.
    new_test();
    set_src(REQ_TCP, 1, 5);
    drive();
    #1;
    repeat (3) step();
    check("t5_pre_valid", eth_tx_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", eth_tx_valid, 1'b0);
    check("t5_rst_last", eth_tx_last, 1'b0);
    check("t5_rst_ready", req_ready, 3'b000);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_fc", frame_count, 16'd0);
    check("t5_rst_grant", grant_id, 2'd0);
    set_src(REQ_TCP, 1, 3);
    set_src(REQ_ICMP, 1, 3);
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    new_test();
    step();
    check("t5_first_grant", grant_id, 2'd0);
    check("t5_first_data", eth_tx_data, 32'h0000_0000);
    repeat (4) step();
    check("t5_second_grant", grant_id, 2'd2);
    check("t5_second_data", eth_tx_data, 32'h0200_0000);
    repeat (3) step();
    check("t5_frame_count", frame_count, 16'd2);

    // Frame counter wrap from 0xFFFF.
    force dut.frame_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_count_q;
    #1;
    check("t6_preload", frame_count, 16'hFFFF);
    new_test();
    set_src(REQ_ARP, 1, 1);
    drive();
    #1;
    repeat (3) step();
    check("t6_wrap", frame_count, 16'h0000);
    check("t6_count", cap_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
